// File: rtl/led_matrix_scan_driver.sv
// Row-scanned LED matrix driver with a double-buffered frame image.
// Ports: iClk, iRst (sync, active-high), iEn, iWr_en/iWr_row/iWr_data
// (back-bank row write), iSwap (bank exchange request), oRow (one-hot
// active-high), oCol (active-low), oFrame_start, oSwap_pending,
// oSwap_done.
module led_matrix_scan_driver #(
  parameter int ROWS         = 5,
  parameter int COLS         = 5,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iEn,
  input  logic                    iWr_en,
  input  logic [$clog2(ROWS)-1:0] iWr_row,
  input  logic [COLS-1:0]         iWr_data,
  input  logic                    iSwap,
  output logic [ROWS-1:0]         oRow,
  output logic [COLS-1:0]         oCol,
  output logic                    oFrame_start,
  output logic                    oSwap_pending,
  output logic                    oSwap_done
);

  localparam int RW   = $clog2(ROWS);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
  localparam bit NOBLANK = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t          state, stateNext;
  logic [RW-1:0]   rowIdx, rowNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            bankPtr, ptrNext;
  logic            swapPend, pendNext;
  logic            boundary;
  logic            wrOk;
  logic [COLS-1:0] frontRow;
  logic [COLS-1:0] bank [2][ROWS];

  logic [ROWS-1:0] rowQ, rowD;
  logic [COLS-1:0] colQ, colD;
  logic            fsQ, fsD;
  logic            sdQ, sdD;

  assign wrOk = iWr_en && (int'(iWr_row) < ROWS);

  always_comb begin
    stateNext = state;
    rowNext   = rowIdx;
    cntNext   = cnt + 1'b1;
    ptrNext   = bankPtr;
    pendNext  = swapPend | iSwap;
    boundary  = 1'b0;
    sdD       = 1'b0;
    unique case (state)
      IDLE: begin
        cntNext = '0;
        rowNext = '0;
        if (iEn) stateNext = NOBLANK ? DRIVE : BLANK;
      end
      BLANK: begin
        if (cnt == BLAST) begin
          stateNext = DRIVE;
          cntNext   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DLAST) begin
          stateNext = NOBLANK ? DRIVE : BLANK;
          cntNext   = '0;
          if (rowIdx == RLAST) begin
            rowNext  = '0;
            boundary = 1'b1;
          end else begin
            rowNext = rowIdx + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
        rowNext   = '0;
      end
    endcase
    if (!iEn) begin
      stateNext = IDLE;
      rowNext   = '0;
      cntNext   = '0;
      boundary  = 1'b0;
    end
    if (boundary && (swapPend || iSwap)) begin
      ptrNext  = ~bankPtr;
      pendNext = 1'b0;
      sdD      = 1'b1;
    end
    // A write landing in the bank that becomes front on this very
    // edge must be visible if row 0 starts driving immediately.
    frontRow = bank[ptrNext][rowNext];
    if (wrOk && (ptrNext != bankPtr) && (iWr_row == rowNext))
      frontRow = iWr_data;
    rowD = '0;
    colD = '1;
    fsD  = 1'b0;
    if (stateNext == DRIVE) begin
      rowD = ROWS'(1) << rowNext;
      colD = ~frontRow;
      fsD  = (rowNext == '0) &&
             ((state != DRIVE) || (cnt == DLAST));
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      rowIdx   <= '0;
      cnt      <= '0;
      bankPtr  <= 1'b0;
      swapPend <= 1'b0;
      rowQ     <= '0;
      colQ     <= '1;
      fsQ      <= 1'b0;
      sdQ      <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        bank[0][r] <= '0;
        bank[1][r] <= '0;
      end
    end else begin
      state    <= stateNext;
      rowIdx   <= rowNext;
      cnt      <= cntNext;
      bankPtr  <= ptrNext;
      swapPend <= pendNext;
      rowQ     <= rowD;
      colQ     <= colD;
      fsQ      <= fsD;
      sdQ      <= sdD;
      if (wrOk) bank[~bankPtr][iWr_row] <= iWr_data;
    end
  end

  assign oRow          = rowQ;
  assign oCol          = colQ;
  assign oFrame_start  = fsQ;
  assign oSwap_pending = swapPend;
  assign oSwap_done    = sdQ;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Bench for led_matrix_scan_driver: two builds (BLANK=2 and BLANK=0)
// share stimulus and are checked against a frame-position model.
module tb_led_matrix_scan_driver;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int DW   = 4;
  int blk [2] = '{2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, wrEn, swap;
  logic [2:0]      wrRow;
  logic [COLS-1:0] wrData;

  logic [ROWS-1:0] oRow [2];
  logic [COLS-1:0] oCol [2];
  logic            oFs [2], oSp [2], oSd [2];

  led_matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)
  ) u0 (
    .iClk(clk), .iRst(rst), .iEn(en), .iWr_en(wrEn),
    .iWr_row(wrRow), .iWr_data(wrData), .iSwap(swap),
    .oRow(oRow[0]), .oCol(oCol[0]), .oFrame_start(oFs[0]),
    .oSwap_pending(oSp[0]), .oSwap_done(oSd[0])
  );

  led_matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)
  ) u1 (
    .iClk(clk), .iRst(rst), .iEn(en), .iWr_en(wrEn),
    .iWr_row(wrRow), .iWr_data(wrData), .iSwap(swap),
    .oRow(oRow[1]), .oCol(oCol[1]), .oFrame_start(oFs[1]),
    .oSwap_pending(oSp[1]), .oSwap_done(oSd[1])
  );

  int checks = 0;
  int failures = 0;

  int   mP [2];
  bit   mRun [2], mPtr [2], mPend [2], mDone [2];
  logic [COLS-1:0] mBank [2][2][ROWS];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input int k);
    int fp;
    bit bnd;
    fp = ROWS * (blk[k] + DW);
    mDone[k] = 1'b0;
    if (rst) begin
      mRun[k] = 0; mP[k] = 0; mPtr[k] = 0; mPend[k] = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) mBank[k][b][r] = '0;
      return;
    end
    if (wrEn && wrRow < ROWS) mBank[k][!mPtr[k]][wrRow] = wrData;
    if (!en) begin
      mRun[k] = 0;
      if (swap) mPend[k] = 1;
    end else if (!mRun[k]) begin
      mRun[k] = 1;
      mP[k] = 0;
      if (swap) mPend[k] = 1;
    end else begin
      bnd = (mP[k] % fp) == fp - 1;
      mP[k]++;
      if (bnd && (mPend[k] || swap)) begin
        mPtr[k] = !mPtr[k];
        mPend[k] = 0;
        mDone[k] = 1;
      end else if (swap) begin
        mPend[k] = 1;
      end
    end
  endtask

  task automatic checkAll();
    int rp, f, row, ph;
    bit drv;
    logic [31:0] eRow, eCol, eFs;
    for (int k = 0; k < 2; k++) begin
      rp = blk[k] + DW;
      eRow = 0; eCol = 32'h1f; eFs = 0;
      if (mRun[k]) begin
        f = mP[k] % (ROWS * rp);
        row = f / rp;
        ph = f % rp;
        drv = ph >= blk[k];
        if (drv) begin
          eRow = 32'(1) << row;
          eCol = {27'd0, ~mBank[k][mPtr[k]][row]};
          eFs = 32'((ph == blk[k]) && (row == 0));
        end
      end
      chk($sformatf("row_b%0d", blk[k]), 32'(oRow[k]), eRow);
      chk($sformatf("col_b%0d", blk[k]), 32'(oCol[k]), eCol);
      chk($sformatf("fstart_b%0d", blk[k]), 32'(oFs[k]), eFs);
      chk($sformatf("spend_b%0d", blk[k]), 32'(oSp[k]),
          32'(mPend[k]));
      chk($sformatf("sdone_b%0d", blk[k]), 32'(oSd[k]),
          32'(mDone[k]));
      chk($sformatf("onehot_b%0d", blk[k]), 32'($onehot0(oRow[k])),
          32'd1);
    end
  endtask

  task automatic tick();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic wrRowTask(input int r, input logic [COLS-1:0] d);
    wrEn = 1'b1;
    wrRow = 3'(r);
    wrData = d;
    tick();
    wrEn = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; wrEn = 1'b0; swap = 1'b0;
    wrRow = '0; wrData = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();

    for (int r = 0; r < ROWS; r++) wrRowTask(r, COLS'(1 << r));
    swap = 1'b1; tick(); swap = 1'b0;
    en = 1'b1;
    repeat (70) tick();

    n = 0;
    while (!(mRun[0] && (mP[0] % 30) == 13) && n < 60) begin
      tick(); n++;
    end
    wrRowTask(2, 5'h1f);
    repeat (35) tick();
    swap = 1'b1; tick(); swap = 1'b0;
    repeat (40) tick();

    n = 0;
    while (!(mRun[0] && (mP[0] % 30) == 29) && n < 60) begin
      tick(); n++;
    end
    chk("sync_last_drive", 32'(n < 60), 32'd1);
    swap = 1'b1; tick(); swap = 1'b0;
    chk("swap_done_direct", 32'(oSd[0]), 32'd1);
    chk("swap_pend_direct", 32'(oSp[0]), 32'd0);

    for (int i = 0; i < 3; i++) begin
      swap = 1'b1; tick(); swap = 1'b0;
      repeat (5) tick();
    end
    repeat (40) tick();

    n = 0;
    while (!(mRun[0] && (mP[0] % 30) == 20) && n < 60) begin
      tick(); n++;
    end
    en = 1'b0; tick();
    chk("disable_row", 32'(oRow[0]), 32'd0);
    chk("disable_col", 32'(oCol[0]), 32'h1f);
    repeat (3) tick();
    en = 1'b1;
    repeat (40) tick();

    swap = 1'b1; tick(); swap = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_row", 32'(oRow[0]), 32'd0);
    chk("rst_col", 32'(oCol[0]), 32'h1f);
    chk("rst_pend", 32'(oSp[0]), 32'd0);
    repeat (5) tick();
    swap = 1'b1; tick(); swap = 1'b0;
    repeat (70) tick();

    repeat (800) begin
      wrEn   = ($urandom_range(0, 3) == 0);
      wrRow  = 3'($urandom_range(0, 7));
      wrData = 5'($urandom);
      swap   = ($urandom_range(0, 15) == 0);
      en     = ($urandom_range(0, 49) != 0);
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; wrEn = 1'b0; swap = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
